// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the CPU-side coprocessor issue block.
//   - FSM state encoding (IDLE, ISSUE, WAIT, WB)
//   - result-code constants (zero means success)
//   - field widths for the register address and the result code
//   - packed struct holding a captured coprocessor response
package scarv_cop_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int RESULT_W   = 3;
  localparam int DATA_W     = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic [RESULT_W-1:0] RESULT_SUCCESS = '0;

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
    logic [RESULT_W-1:0]   result;
  } cop_rsp_t;

endpackage

// File: rtl/scarv_cop_watchdog.sv
// Saturating cycle counter guarding one outstanding coprocessor instruction.
// Ports:
//   g_clk, g_resetn : clock and asynchronous active-low reset
//   clear           : synchronous clear (takes priority over counting)
//   count_en        : advance the counter by one this cycle
//   saturated       : counter has reached TIMEOUT_CYCLES and holds there
module scarv_cop_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic clear,
  input  logic count_en,
  output logic saturated
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign saturated = (count == LIMIT);

endmodule

// File: rtl/scarv_cpu_cop_issue.sv
// Issues one instruction at a time from the CPU pipeline to the coprocessor,
// waits for its response and presents a one-cycle writeback to the pipeline.
// Ports:
//   g_clk, g_resetn                  : clock, asynchronous active-low reset
//   pipe_valid/ready/insn/rs1        : instruction hand-off from the pipeline
//   cpu_insn_req/enc/rs1, cop_insn_ack : request channel to the coprocessor
//   cop_insn_rsp, cop_w*/cop_result  : response channel from the coprocessor
//   cpu_insn_ack                     : response acknowledge (held in WAIT)
//   wb_*                             : writeback strobe and fields (WB only)
//   cop_hang                         : watchdog expired on the outstanding insn
module scarv_cpu_cop_issue
  import scarv_cop_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  pipe_valid,
  output logic                  pipe_ready,
  input  logic [DATA_W-1:0]     pipe_insn,
  input  logic [DATA_W-1:0]     pipe_rs1,
  output logic                  cpu_insn_req,
  input  logic                  cop_insn_ack,
  output logic [DATA_W-1:0]     cpu_insn_enc,
  output logic [DATA_W-1:0]     cpu_rs1,
  input  logic                  cop_wen,
  input  logic [REG_ADDR_W-1:0] cop_waddr,
  input  logic [DATA_W-1:0]     cop_wdata,
  input  logic [RESULT_W-1:0]   cop_result,
  input  logic                  cop_insn_rsp,
  output logic                  cpu_insn_ack,
  output logic                  wb_valid,
  output logic                  wb_wen,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic [RESULT_W-1:0]   wb_result,
  output logic                  wb_trap,
  output logic                  cop_hang
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] insn_q;
  logic [DATA_W-1:0] rs1_q;
  cop_rsp_t          rsp_q;
  logic              accept;
  logic              issued;
  logic              complete;
  logic              busy;
  logic              in_wb;
  logic              wdog_sat;

  assign accept   = (state == ST_IDLE)  && pipe_valid;
  assign issued   = (state == ST_ISSUE) && cop_insn_ack;
  // A response only counts once the request has been accepted; any response
  // seen during ISSUE (including the acceptance cycle) is ignored.
  assign complete = (state == ST_WAIT)  && cop_insn_rsp;
  assign busy     = (state == ST_ISSUE) || (state == ST_WAIT);
  assign in_wb    = (state == ST_WB);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_ISSUE;
      ST_ISSUE: if (issued)   state_nxt = ST_WAIT;
      ST_WAIT:  if (complete) state_nxt = ST_WB;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state  <= ST_IDLE;
      insn_q <= '0;
      rs1_q  <= '0;
      rsp_q  <= '0;
    end else begin
      state <= state_nxt;
      // Operands are only captured in IDLE, so they stay stable through ISSUE.
      if (accept) begin
        insn_q <= pipe_insn;
        rs1_q  <= pipe_rs1;
      end
      if (complete) begin
        rsp_q.wen    <= cop_wen && (cop_waddr != '0);
        rsp_q.waddr  <= cop_waddr;
        rsp_q.wdata  <= cop_wdata;
        rsp_q.result <= cop_result;
      end
    end
  end

  scarv_cop_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .clear     (state == ST_IDLE),
    .count_en  (busy),
    .saturated (wdog_sat)
  );

  // The counter only clears back in IDLE, so qualifying with busy makes the
  // flag drop as soon as the instruction completes (WB entry).
  assign cop_hang     = wdog_sat && busy;

  assign pipe_ready   = (state == ST_IDLE);
  assign cpu_insn_req = (state == ST_ISSUE);
  assign cpu_insn_ack = (state == ST_WAIT);
  assign cpu_insn_enc = insn_q;
  assign cpu_rs1      = rs1_q;

  assign wb_valid  = in_wb;
  assign wb_wen    = in_wb && rsp_q.wen;
  assign wb_waddr  = in_wb ? rsp_q.waddr  : '0;
  assign wb_wdata  = in_wb ? rsp_q.wdata  : '0;
  assign wb_result = in_wb ? rsp_q.result : '0;
  assign wb_trap   = in_wb && (rsp_q.result != RESULT_SUCCESS);

endmodule

// File: tb/tb_scarv_cpu_cop_issue.sv
// Self-checking bench for scarv_cpu_cop_issue. The bench plays both the CPU
// pipeline and the coprocessor; each transaction is described by its operands,
// its ack/rsp delays and its response, and the expected pipeline-visible
// behaviour is derived from those directly.
module tb_scarv_cpu_cop_issue;

  localparam int TIMEOUT = 16;

  logic        g_clk;
  logic        g_resetn;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [31:0] pipe_insn;
  logic [31:0] pipe_rs1;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [2:0]  wb_result;
  logic        wb_trap;
  logic        cop_hang;

  int checks = 0;
  int errors = 0;
  int wb_pulses = 0;

  scarv_cpu_cop_issue #(
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .pipe_valid   (pipe_valid),
    .pipe_ready   (pipe_ready),
    .pipe_insn    (pipe_insn),
    .pipe_rs1     (pipe_rs1),
    .cpu_insn_req (cpu_insn_req),
    .cop_insn_ack (cop_insn_ack),
    .cpu_insn_enc (cpu_insn_enc),
    .cpu_rs1      (cpu_rs1),
    .cop_wen      (cop_wen),
    .cop_waddr    (cop_waddr),
    .cop_wdata    (cop_wdata),
    .cop_result   (cop_result),
    .cop_insn_rsp (cop_insn_rsp),
    .cpu_insn_ack (cpu_insn_ack),
    .wb_valid     (wb_valid),
    .wb_wen       (wb_wen),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .wb_result    (wb_result),
    .wb_trap      (wb_trap),
    .cop_hang     (cop_hang)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic rand_rsp_fields();
    cop_wen    = 1'($urandom_range(0, 1));
    cop_waddr  = 5'($urandom);
    cop_wdata  = $urandom;
    cop_result = 3'($urandom);
  endtask

  // One complete instruction. 'k' counts edges since pipeline acceptance,
  // which is exactly the number of cycles the instruction has spent in
  // ISSUE+WAIT, so the watchdog is expected to show high once k >= TIMEOUT.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                         input int ack_dly, input int rsp_dly,
                         input logic wen, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic [2:0] result);
    int k;
    check("idle_ready", pipe_ready, 1);
    check("idle_wb_valid", wb_valid, 0);
    check("idle_req", cpu_insn_req, 0);
    // Accept cycle: coprocessor strobes while IDLE must have no effect.
    pipe_valid   = 1'b1;
    pipe_insn    = insn;
    pipe_rs1     = rs1;
    cop_insn_ack = 1'($urandom_range(0, 1));
    cop_insn_rsp = 1'($urandom_range(0, 1));
    rand_rsp_fields();
    step();
    k = 0;
    // ISSUE: request held with stable operands until the ack edge.
    for (int i = 0; i <= ack_dly; i++) begin
      pipe_valid   = 1'($urandom_range(0, 1));
      pipe_insn    = $urandom;
      pipe_rs1     = $urandom;
      cop_insn_rsp = 1'($urandom_range(0, 1));
      cop_insn_ack = (i == ack_dly);
      rand_rsp_fields();
      check("issue_req", cpu_insn_req, 1);
      check("issue_enc", cpu_insn_enc, insn);
      check("issue_rs1", cpu_rs1, rs1);
      check("issue_ready", pipe_ready, 0);
      check("issue_rsp_ack", cpu_insn_ack, 0);
      check("issue_wb_valid", wb_valid, 0);
      check("issue_hang", cop_hang, (k >= TIMEOUT));
      step();
      k++;
    end
    // WAIT: response acknowledge held until the response edge.
    for (int i = 0; i <= rsp_dly; i++) begin
      pipe_valid   = 1'($urandom_range(0, 1));
      cop_insn_ack = 1'($urandom_range(0, 1));
      cop_insn_rsp = (i == rsp_dly);
      if (i == rsp_dly) begin
        cop_wen    = wen;
        cop_waddr  = waddr;
        cop_wdata  = wdata;
        cop_result = result;
      end else begin
        rand_rsp_fields();
      end
      check("wait_req", cpu_insn_req, 0);
      check("wait_rsp_ack", cpu_insn_ack, 1);
      check("wait_ready", pipe_ready, 0);
      check("wait_wb_valid", wb_valid, 0);
      check("wait_wb_wdata", wb_wdata, 0);
      check("wait_hang", cop_hang, (k >= TIMEOUT));
      step();
      k++;
    end
    pipe_valid   = 1'b0;
    cop_insn_ack = 1'b0;
    cop_insn_rsp = 1'b0;
    rand_rsp_fields();
    // WB: single strobe with the response as seen through the x0 rule.
    if (wb_valid === 1'b1) wb_pulses++;
    check("wb_valid", wb_valid, 1);
    check("wb_wen", wb_wen, (wen && (waddr != 5'd0)));
    check("wb_waddr", wb_waddr, waddr);
    check("wb_wdata", wb_wdata, wdata);
    check("wb_result", wb_result, result);
    check("wb_trap", wb_trap, (result != 3'd0));
    check("wb_hang", cop_hang, 0);
    check("wb_ready", pipe_ready, 0);
    step();
    check("post_wb_valid", wb_valid, 0);
    check("post_wb_wen", wb_wen, 0);
  endtask

  initial begin
    int ack_d;
    int rsp_d;
    logic [4:0] addr;

    g_resetn     = 1'b0;
    pipe_valid   = 1'b0;
    pipe_insn    = '0;
    pipe_rs1     = '0;
    cop_insn_ack = 1'b0;
    cop_insn_rsp = 1'b0;
    cop_wen      = 1'b0;
    cop_waddr    = '0;
    cop_wdata    = '0;
    cop_result   = '0;
    step();
    step();
    check("rst_req", cpu_insn_req, 0);
    check("rst_rsp_ack", cpu_insn_ack, 0);
    check("rst_enc", cpu_insn_enc, 0);
    check("rst_rs1", cpu_rs1, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_wdata", wb_wdata, 0);
    check("rst_hang", cop_hang, 0);
    g_resetn = 1'b1;
    check("rel_ready", pipe_ready, 1);

    // Minimum-latency transaction with a successful GPR write.
    run_txn(32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 1'b1, 5'd5, 32'hA5A5_A5A5, 3'd0);
    // Ack withheld for 7 cycles.
    run_txn(32'hCAFE_0001, 32'h0BAD_F00D, 7, 0, 1'b1, 5'd9, 32'h1111_2222, 3'd0);
    // Write to x0 suppressed, nonzero result traps.
    run_txn(32'h0000_0033, 32'h7777_7777, 0, 1, 1'b1, 5'd0, 32'h5555_AAAA, 3'd3);
    // Response withheld 40 cycles: watchdog saturates, then clears on WB.
    run_txn(32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 40, 1'b1, 5'd31, 32'h8000_0001, 3'd0);
    // Next instruction starts with a fresh watchdog count.
    run_txn(32'h2468_ACE0, 32'h1357_9BDF, 3, 4, 1'b0, 5'd7, 32'h0000_00FF, 3'd1);

    // Reset while a hung instruction sits in WAIT.
    pipe_valid = 1'b1;
    pipe_insn  = 32'h9999_0000;
    pipe_rs1   = 32'h0000_9999;
    step();
    pipe_valid   = 1'b0;
    cop_insn_ack = 1'b1;
    step();
    cop_insn_ack = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("pre_rst_hang", cop_hang, 1);
    check("pre_rst_rsp_ack", cpu_insn_ack, 1);
    #3;
    g_resetn = 1'b0;
    #1;
    check("arst_rsp_ack", cpu_insn_ack, 0);
    check("arst_req", cpu_insn_req, 0);
    check("arst_enc", cpu_insn_enc, 0);
    check("arst_rs1", cpu_rs1, 0);
    check("arst_hang", cop_hang, 0);
    check("arst_wb_valid", wb_valid, 0);
    cop_insn_rsp = 1'b1;
    cop_insn_ack = 1'b1;
    cop_wen      = 1'b1;
    cop_waddr    = 5'd3;
    cop_wdata    = 32'h3333_3333;
    step();
    check("arst_hold_wb_valid", wb_valid, 0);
    g_resetn = 1'b1;
    check("arst_rel_ready", pipe_ready, 1);
    // Late response and ack while IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      check("late_rsp_wb_valid", wb_valid, 0);
      check("late_rsp_ready", pipe_ready, 1);
      check("late_rsp_req", cpu_insn_req, 0);
      check("late_rsp_ack", cpu_insn_ack, 0);
    end
    cop_insn_rsp = 1'b0;
    cop_insn_ack = 1'b0;

    // Back-to-back randomized traffic.
    wb_pulses = 0;
    for (int n = 0; n < 100; n++) begin
      ack_d = $urandom_range(0, 5);
      rsp_d = $urandom_range(0, 5);
      addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn($urandom, $urandom, ack_d, rsp_d, 1'($urandom_range(0, 1)), addr,
              $urandom, ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom));
    end
    check("b2b_wb_pulses", wb_pulses, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
